// File: rtl/fetch_sequencer.sv
// Program-counter sequencer for the instruction ROM: start, stall, jump,
// relative branch and halt control, with run status and cycle count.
module fetch_sequencer #(
  parameter int unsigned D          = 12,
  parameter logic [D-1:0] START_ADDR = '0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stall,
  input  logic             Halt,
  input  logic             JumpEn,
  input  logic             JumpRel,
  input  logic [D-1:0]     Target,
  output logic [D-1:0]     PrgCtr,
  output logic             FetchValid,
  output logic             Busy,
  output logic             Done,
  output logic             WrapErr,
  output logic [CNT_W-1:0] CycleCnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [D-1:0]     pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= START_ADDR;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    wrap_d  = wrap_q;
    unique case (state_q)
      IDLE: begin
        pc_d = START_ADDR;
        if (Start) begin
          state_d = RUN;
          cnt_d   = '0;
          wrap_d  = 1'b0;
        end
      end
      RUN: begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (Halt) begin
          state_d = DONE;
        end else if (Stall) begin
          pc_d = pc_q;
        end else if (JumpEn) begin
          // Target is already D bits wide, so the D-bit add is the
          // sign-extended, modulo-2**D relative branch.
          pc_d = JumpRel ? pc_q + Target : Target;
        end else begin
          pc_d = pc_q + 1'b1;
          if (pc_q == '1) wrap_d = 1'b1;
        end
      end
      DONE: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = START_ADDR;
          cnt_d   = '0;
          wrap_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = START_ADDR;
      end
    endcase
  end

  assign PrgCtr     = pc_q;
  assign FetchValid = (state_q == RUN);
  assign Busy       = (state_q == RUN);
  assign Done       = (state_q == DONE);
  assign WrapErr    = wrap_q;
  assign CycleCnt   = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a vector table for the main flow plus
// hand sequences for reset, sequential wrap and counter saturation.
module tb_fetch_sequencer;

  logic        Clk = 1'b0;
  logic        Reset, Start, Stall, Halt, JumpEn, JumpRel;
  logic [11:0] Target;

  logic [11:0] pc_a, pc_w, pc_c;
  logic        fv_a, busy_a, done_a, wrap_a;
  logic        fv_w, busy_w, done_w, wrap_w;
  logic        fv_c, busy_c, done_c, wrap_c;
  logic [15:0] cnt_a, cnt_w;
  logic [3:0]  cnt_c;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  fetch_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .Halt(Halt),
    .JumpEn(JumpEn), .JumpRel(JumpRel), .Target(Target),
    .PrgCtr(pc_a), .FetchValid(fv_a), .Busy(busy_a), .Done(done_a),
    .WrapErr(wrap_a), .CycleCnt(cnt_a)
  );

  fetch_sequencer #(.START_ADDR(12'hFFE)) dut_w (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .Halt(Halt),
    .JumpEn(JumpEn), .JumpRel(JumpRel), .Target(Target),
    .PrgCtr(pc_w), .FetchValid(fv_w), .Busy(busy_w), .Done(done_w),
    .WrapErr(wrap_w), .CycleCnt(cnt_w)
  );

  fetch_sequencer #(.CNT_W(4)) dut_c (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .Halt(Halt),
    .JumpEn(JumpEn), .JumpRel(JumpRel), .Target(Target),
    .PrgCtr(pc_c), .FetchValid(fv_c), .Busy(busy_c), .Done(done_c),
    .WrapErr(wrap_c), .CycleCnt(cnt_c)
  );

  typedef struct {
    logic        st, sl, hl, je, jr;
    logic [11:0] tg;
    logic [11:0] pc;
    logic        busy, done, wrap;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic sl, input logic hl,
                       input logic je, input logic jr, input logic [11:0] tg);
    Start = st; Stall = sl; Halt = hl; JumpEn = je; JumpRel = jr; Target = tg;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 12'h000);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  initial begin
    //         st sl hl je jr tg       pc       bsy dn wr cnt
    vecs[0]  = '{1, 0, 0, 0, 0, 12'h000, 12'h000, 1, 0, 0, 16'd0};
    vecs[1]  = '{0, 0, 0, 0, 0, 12'h000, 12'h001, 1, 0, 0, 16'd1};
    vecs[2]  = '{0, 0, 0, 0, 0, 12'h000, 12'h002, 1, 0, 0, 16'd2};
    vecs[3]  = '{0, 0, 0, 0, 0, 12'h000, 12'h003, 1, 0, 0, 16'd3};
    vecs[4]  = '{0, 0, 0, 0, 0, 12'h000, 12'h004, 1, 0, 0, 16'd4};
    vecs[5]  = '{0, 0, 0, 0, 0, 12'h000, 12'h005, 1, 0, 0, 16'd5};
    vecs[6]  = '{0, 0, 1, 0, 0, 12'h000, 12'h005, 0, 1, 0, 16'd6};
    vecs[7]  = '{0, 1, 1, 1, 0, 12'h100, 12'h005, 0, 1, 0, 16'd6};
    vecs[8]  = '{1, 0, 0, 0, 0, 12'h000, 12'h000, 1, 0, 0, 16'd0};
    vecs[9]  = '{0, 0, 0, 1, 0, 12'h010, 12'h010, 1, 0, 0, 16'd1};
    vecs[10] = '{0, 0, 0, 1, 0, 12'h100, 12'h100, 1, 0, 0, 16'd2};
    vecs[11] = '{0, 0, 0, 1, 1, 12'hFFE, 12'h0FE, 1, 0, 0, 16'd3};
    vecs[12] = '{0, 1, 0, 1, 0, 12'h300, 12'h0FE, 1, 0, 0, 16'd4};
    vecs[13] = '{0, 1, 0, 1, 0, 12'h300, 12'h0FE, 1, 0, 0, 16'd5};
    vecs[14] = '{0, 0, 0, 0, 0, 12'h000, 12'h0FF, 1, 0, 0, 16'd6};
    vecs[15] = '{1, 0, 0, 0, 0, 12'h000, 12'h100, 1, 0, 0, 16'd7};
    vecs[16] = '{0, 0, 0, 1, 0, 12'h020, 12'h020, 1, 0, 0, 16'd8};
    vecs[17] = '{0, 1, 1, 1, 0, 12'h500, 12'h020, 0, 1, 0, 16'd9};
    vecs[18] = '{1, 0, 0, 0, 0, 12'h000, 12'h000, 1, 0, 0, 16'd0};
    vecs[19] = '{0, 0, 0, 1, 1, 12'hFFF, 12'hFFF, 1, 0, 0, 16'd1};
    vecs[20] = '{0, 0, 0, 1, 1, 12'h002, 12'h001, 1, 0, 0, 16'd2};

    Reset = 1'b0;
    do_reset();
    chk("rst.pc", 32'(pc_a), 32'h000);
    chk("rst.busy", 32'(busy_a), 0);
    chk("rst.fv", 32'(fv_a), 0);
    chk("rst.done", 32'(done_a), 0);
    chk("rst.wrap", 32'(wrap_a), 0);
    chk("rst.cnt", 32'(cnt_a), 0);
    chk("rst.pc_w", 32'(pc_w), 32'hFFE);

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].st, vecs[i].sl, vecs[i].hl, vecs[i].je, vecs[i].jr, vecs[i].tg);
      step();
      chk($sformatf("v%0d.pc", i), 32'(pc_a), 32'(vecs[i].pc));
      chk($sformatf("v%0d.busy", i), 32'(busy_a), 32'(vecs[i].busy));
      chk($sformatf("v%0d.fv", i), 32'(fv_a), 32'(vecs[i].busy));
      chk($sformatf("v%0d.done", i), 32'(done_a), 32'(vecs[i].done));
      chk($sformatf("v%0d.wrap", i), 32'(wrap_a), 32'(vecs[i].wrap));
      chk($sformatf("v%0d.cnt", i), 32'(cnt_a), 32'(vecs[i].cnt));
    end

    // Reset in the middle of a run.
    do_reset();
    drive(1, 0, 0, 0, 0, 12'h000);
    step();
    drive(0, 0, 0, 1, 0, 12'h025);
    step();
    chk("mid.pc_pre", 32'(pc_a), 32'h025);
    drive(0, 0, 0, 0, 0, 12'h000);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("mid.pc", 32'(pc_a), 32'h000);
    chk("mid.busy", 32'(busy_a), 0);
    chk("mid.done", 32'(done_a), 0);
    chk("mid.cnt", 32'(cnt_a), 0);
    step();
    chk("idle.pc", 32'(pc_a), 32'h000);
    chk("idle.busy", 32'(busy_a), 0);

    // Sequential wrap on the START_ADDR=0xFFE instance.
    do_reset();
    drive(1, 0, 0, 0, 0, 12'h000);
    step();
    drive(0, 0, 0, 0, 0, 12'h000);
    chk("wrap.pc0", 32'(pc_w), 32'hFFE);
    chk("wrap.err0", 32'(wrap_w), 0);
    step();
    chk("wrap.pc1", 32'(pc_w), 32'hFFF);
    chk("wrap.err1", 32'(wrap_w), 0);
    step();
    chk("wrap.pc2", 32'(pc_w), 32'h000);
    chk("wrap.err2", 32'(wrap_w), 1);
    step();
    chk("wrap.pc3", 32'(pc_w), 32'h001);
    chk("wrap.sticky", 32'(wrap_w), 1);
    drive(0, 0, 1, 0, 0, 12'h000);
    step();
    chk("wrap.done", 32'(done_w), 1);
    chk("wrap.sticky_done", 32'(wrap_w), 1);
    drive(1, 0, 0, 0, 0, 12'h000);
    step();
    chk("wrap.restart_pc", 32'(pc_w), 32'hFFE);
    chk("wrap.cleared", 32'(wrap_w), 0);

    // Counter saturation on the CNT_W=4 instance, with Start held during RUN.
    do_reset();
    drive(1, 0, 0, 0, 0, 12'h000);
    step();
    chk("sat.cnt0", 32'(cnt_c), 0);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 15) chk("sat.cnt15", 32'(cnt_c), 15);
    end
    chk("sat.cnt20", 32'(cnt_c), 15);
    chk("sat.pc", 32'(pc_c), 32'd20);
    chk("sat.busy", 32'(busy_c), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
